pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: in-order pipeline control for hazards, forwarding,
// stall/flush sequencing and saturating event counters.
module pipe_ctrl #(
  parameter int STAGES      = 4,
  parameter int RW          = 5,
  parameter int FWD_EN      = 1,
  parameter int REDIR_STAGE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [RW-1:0]     id_rs1,
  input  logic [RW-1:0]     id_rs2,
  input  logic              id_rs1_use,
  input  logic              id_rs2_use,
  input  logic [RW-1:0]     id_rd,
  input  logic              id_rd_wen,
  input  logic              id_is_load,
  input  logic              redirect,
  input  logic              ext_stall,
  output logic [STAGES-1:0] stage_valid,
  output logic [STAGES-1:0] stage_en,
  output logic [2:0]        fwd_rs1_sel,
  output logic [2:0]        fwd_rs2_sel,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
);

  logic [STAGES-1:0]         vld;
  logic [STAGES-1:0][RW-1:0] rd_q;
  logic [STAGES-1:0]         wen_q;
  logic                      ld0;
  logic                      ld1;
  logic [RW-1:0]             rs1_q;
  logic [RW-1:0]             rs2_q;
  logic                      use1_q;
  logic                      use2_q;

  logic [STAGES-1:0] m1;
  logic [STAGES-1:0] m2;
  logic [STAGES-1:0] en;
  logic [2:0]        sel1;
  logic [2:0]        sel2;
  logic              hazard;
  logic              issue;
  logic              accept;

  // Source-vs-destination matches against every older stage
  always_comb begin
    m1 = '0;
    m2 = '0;
    for (int i = 1; i < STAGES; i++) begin
      m1[i] = vld[i] & wen_q[i] & (rd_q[i] == rs1_q)
            & (rs1_q != '0) & use1_q;
      m2[i] = vld[i] & wen_q[i] & (rd_q[i] == rs2_q)
            & (rs2_q != '0) & use2_q;
    end
  end

  // Hazard and nearest-producer forwarding select
  always_comb begin
    hazard = 1'b0;
    sel1   = '0;
    sel2   = '0;
    if (FWD_EN != 0) begin
      hazard = (m1[1] | m2[1]) & ld1;
      for (int i = STAGES - 1; i >= 1; i--) begin
        if (m1[i]) sel1 = 3'(i);
        if (m2[i]) sel2 = 3'(i);
      end
    end else begin
      hazard = (|m1) | (|m2);
    end
  end

  assign issue    = vld[0] & ~hazard & ~ext_stall & ~redirect;
  assign if_ready = ~vld[0] | issue | redirect;
  assign accept   = if_valid & if_ready & ~redirect;

  // Per-stage load enables; held stages keep their content
  always_comb begin
    en    = '0;
    en[0] = redirect | issue | accept;
    for (int i = 1; i < STAGES; i++) begin
      if (ext_stall) en[i] = redirect & (i < REDIR_STAGE);
      else           en[i] = 1'b1;
    end
  end

  // Pipeline entries and event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld       <= '0;
      rd_q      <= '0;
      wen_q     <= '0;
      ld0       <= 1'b0;
      ld1       <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      use1_q    <= 1'b0;
      use2_q    <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (redirect) begin
        vld[0] <= 1'b0;
      end else if (accept) begin
        vld[0]   <= 1'b1;
        rs1_q    <= id_rs1;
        rs2_q    <= id_rs2;
        use1_q   <= id_rs1_use;
        use2_q   <= id_rs2_use;
        rd_q[0]  <= id_rd;
        wen_q[0] <= id_rd_wen;
        ld0      <= id_is_load;
      end else if (issue) begin
        vld[0] <= 1'b0;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (en[i]) begin
          if (ext_stall) begin
            vld[i] <= 1'b0;
          end else if (i == 1) begin
            vld[1]   <= issue;
            rd_q[1]  <= rd_q[0];
            wen_q[1] <= wen_q[0];
            ld1      <= ld0;
          end else begin
            vld[i]   <= vld[i-1]
                      & ~(redirect & (i <= REDIR_STAGE));
            rd_q[i]  <= rd_q[i-1];
            wen_q[i] <= wen_q[i-1];
          end
        end
      end
      if (vld[0] & ~issue & ~redirect & ~(&stall_cnt))
        stall_cnt <= stall_cnt + 32'd1;
      if (redirect & ~(&flush_cnt))
        flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign stage_valid = vld;
  assign stage_en    = en;
  assign fwd_rs1_sel = sel1;
  assign fwd_rs2_sel = sel2;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed bench for pipe_ctrl, forwarding and
// non-forwarding builds side by side against one reference model.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic if_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic id_rs1_use = 0, id_rs2_use = 0;
  logic id_rd_wen = 0, id_is_load = 0;
  logic redirect = 0, ext_stall = 0;

  logic [1:0]       rdy;
  logic [1:0][3:0]  sv, se;
  logic [1:0][2:0]  f1, f2;
  logic [1:0][31:0] sc, fc;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.FWD_EN(1)) u_fwd (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_ready(rdy[0]),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use),
    .id_rd(id_rd), .id_rd_wen(id_rd_wen),
    .id_is_load(id_is_load),
    .redirect(redirect), .ext_stall(ext_stall),
    .stage_valid(sv[0]), .stage_en(se[0]),
    .fwd_rs1_sel(f1[0]), .fwd_rs2_sel(f2[0]),
    .stall_cnt(sc[0]), .flush_cnt(fc[0])
  );

  pipe_ctrl #(.FWD_EN(0)) u_nofwd (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_ready(rdy[1]),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use),
    .id_rd(id_rd), .id_rd_wen(id_rd_wen),
    .id_is_load(id_is_load),
    .redirect(redirect), .ext_stall(ext_stall),
    .stage_valid(sv[1]), .stage_en(se[1]),
    .fwd_rs1_sel(f1[1]), .fwd_rs2_sel(f2[1]),
    .stall_cnt(sc[1]), .flush_cnt(fc[1])
  );

  // Reference model: an instruction slot per stage
  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       w;
    logic       ld;
  } ent_t;

  typedef struct packed {
    ent_t [3:0]  p;
    logic [31:0] sc;
    logic [31:0] fc;
  } mst_t;

  mst_t ms [2];
  ent_t cur;

  assign cur = {1'b1, id_rs1, id_rs2, id_rs1_use, id_rs2_use,
                id_rd, id_rd_wen, id_is_load};

  function automatic bit dep(ent_t c, ent_t o, int k);
    logic [4:0] r;
    bit u;
    r = (k == 1) ? c.rs2 : c.rs1;
    u = (k == 1) ? c.u2 : c.u1;
    return o.v && o.w && u && (r != 5'd0) && (o.rd == r);
  endfunction

  // A consumer waits on any older writer, or only on a load
  // directly ahead of it when results can be bypassed
  function automatic bit m_hz(mst_t s, bit fwd);
    bit h;
    h = 0;
    for (int k = 0; k < 2; k++)
      for (int i = 1; i < 4; i++)
        if (dep(s.p[0], s.p[i], k) &&
            (!fwd || (i == 1 && s.p[1].ld)))
          h = 1;
    return h;
  endfunction

  // Youngest older writer supplies the operand
  function automatic logic [2:0] m_sel(mst_t s, bit fwd, int k);
    if (!fwd) return 3'd0;
    for (int i = 1; i < 4; i++)
      if (dep(s.p[0], s.p[i], k)) return 3'(i);
    return 3'd0;
  endfunction

  function automatic bit m_iss(mst_t s, bit fwd, bit rdr, bit xs);
    return s.p[0].v && !m_hz(s, fwd) && !xs && !rdr;
  endfunction

  function automatic logic [31:0] inc(logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  function automatic mst_t m_step(mst_t s, bit fwd, bit iv,
                                  ent_t inp, bit rdr, bit xs);
    mst_t n;
    bit iss, ready;
    n     = s;
    iss   = m_iss(s, fwd, rdr, xs);
    ready = !s.p[0].v || iss || rdr;
    if (s.p[0].v && !iss && !rdr) n.sc = inc(s.sc);
    if (rdr) n.fc = inc(s.fc);
    if (rdr)              n.p[0].v = 1'b0;
    else if (iv && ready) n.p[0] = inp;
    else if (iss)         n.p[0].v = 1'b0;
    if (!xs) begin
      n.p[3] = s.p[2];
      n.p[2] = s.p[1];
      n.p[1] = s.p[0];
      n.p[1].v = iss;
    end
    return n;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms[0] <= '0;
      ms[1] <= '0;
    end else begin
      for (int k = 0; k < 2; k++)
        ms[k] <= m_step(ms[k], k == 0, if_valid, cur,
                        redirect, ext_stall);
    end
  end

  // Every-cycle comparison of both builds against the model
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      mst_t s;
      bit iss, er, fw;
      logic [3:0] esv, ese;
      s   = ms[k];
      fw  = (k == 0);
      iss = m_iss(s, fw, redirect, ext_stall);
      er  = !s.p[0].v || iss || redirect;
      esv = {s.p[3].v, s.p[2].v, s.p[1].v, s.p[0].v};
      ese[0]   = redirect || iss || (if_valid && er);
      ese[3:1] = ext_stall ? 3'b000 : 3'b111;
      chk($sformatf("if_ready%0d", k), 32'(rdy[k]), 32'(er));
      chk($sformatf("stage_valid%0d", k), 32'(sv[k]), 32'(esv));
      chk($sformatf("stage_en%0d", k), 32'(se[k]), 32'(ese));
      chk($sformatf("stall_cnt%0d", k), sc[k], s.sc);
      chk($sformatf("flush_cnt%0d", k), fc[k], s.fc);
      if (s.p[0].v && (!fw || !m_hz(s, fw))) begin
        chk($sformatf("fwd1_%0d", k), 32'(f1[k]),
            32'(m_sel(s, fw, 0)));
        chk($sformatf("fwd2_%0d", k), 32'(f2[k]),
            32'(m_sel(s, fw, 1)));
      end
    end
  end

  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_i(logic [4:0] rd, logic w, logic ld,
                       logic [4:0] r1, logic u1,
                       logic [4:0] r2, logic u2);
    if_valid   = 1'b1;
    id_rd      = rd;
    id_rd_wen  = w;
    id_is_load = ld;
    id_rs1     = r1;
    id_rs1_use = u1;
    id_rs2     = r2;
    id_rs2_use = u2;
  endtask

  task automatic put(logic [4:0] rd, logic w, logic ld,
                     logic [4:0] r1, logic u1,
                     logic [4:0] r2, logic u2);
    set_i(rd, w, ld, r1, u1, r2, u2);
    cyc();
  endtask

  task automatic idle(int n);
    if_valid   = 1'b0;
    id_rs1_use = 1'b0;
    id_rs2_use = 1'b0;
    id_rd_wen  = 1'b0;
    id_is_load = 1'b0;
    cyc(n);
  endtask

  initial begin
    cyc(2);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_sv%0d", k), 32'(sv[k]), 0);
      chk($sformatf("rst_rdy%0d", k), 32'(rdy[k]), 1);
      chk($sformatf("rst_sc%0d", k), sc[k], 0);
    end

    // release mid-cycle with an instruction already offered
    set_i(5'd1, 1, 0, 5'd0, 0, 5'd0, 0);
    rst_n = 1'b1;
    cyc();
    chk("first_accept", 32'(sv[0]), 32'b0001);
    put(5'd2, 1, 0, 5'd0, 0, 5'd0, 0);
    put(5'd3, 1, 0, 5'd0, 0, 5'd0, 0);
    put(5'd4, 1, 0, 5'd0, 0, 5'd0, 0);
    chk("b2b_full0", 32'(sv[0]), 32'b1111);
    chk("b2b_full1", 32'(sv[1]), 32'b1111);
    idle(3);
    chk("b2b_tail", 32'(sv[0]), 32'b1000);
    idle(1);
    chk("b2b_sc0", sc[0], 0);
    chk("b2b_sc1", sc[1], 0);

    // load x5 then consumer of x5
    put(5'd5, 1, 1, 5'd0, 0, 5'd0, 0);
    put(5'd8, 1, 0, 5'd5, 1, 5'd0, 0);
    chk("ld_use_sv", 32'(sv[0]), 32'b0011);
    idle(1);
    chk("ld_bubble_sv", 32'(sv[0]), 32'b0101);
    chk("ld_sc0", sc[0], 1);
    chk("ld_fwd1", 32'(f1[0]), 2);
    idle(7);
    chk("ld_sc0_end", sc[0], 1);
    chk("ld_sc1_end", sc[1], 3);

    // ALU producer x6 then consumer on rs2
    put(5'd6, 1, 0, 5'd0, 0, 5'd0, 0);
    put(5'd7, 1, 0, 5'd0, 0, 5'd6, 1);
    chk("alu_fwd2_0", 32'(f2[0]), 1);
    chk("alu_fwd2_1", 32'(f2[1]), 0);
    idle(8);
    chk("alu_sc0", sc[0], 1);
    chk("alu_sc1", sc[1], 6);

    // x0 never creates a dependence
    put(5'd0, 1, 1, 5'd0, 0, 5'd0, 0);
    put(5'd9, 1, 0, 5'd0, 1, 5'd0, 1);
    chk("x0_fwd1", 32'(f1[0]), 0);
    idle(6);
    chk("x0_sc0", sc[0], 1);
    chk("x0_sc1", sc[1], 6);

    // redirect while decode is occupied; same-cycle fetch dropped
    put(5'd10, 1, 0, 5'd0, 0, 5'd0, 0);
    put(5'd11, 1, 0, 5'd0, 0, 5'd0, 0);
    redirect = 1'b1;
    set_i(5'd12, 1, 0, 5'd0, 0, 5'd0, 0);
    cyc();
    redirect = 1'b0;
    chk("redir_sv0", 32'(sv[0]), 32'b0100);
    chk("redir_sv1", 32'(sv[1]), 32'b0100);
    chk("redir_fc0", fc[0], 1);
    chk("redir_fc1", fc[1], 1);
    idle(4);

    // external stall for three cycles
    put(5'd13, 1, 0, 5'd0, 0, 5'd0, 0);
    put(5'd14, 1, 0, 5'd0, 0, 5'd0, 0);
    ext_stall = 1'b1;
    set_i(5'd15, 1, 0, 5'd0, 0, 5'd0, 0);
    cyc(3);
    chk("xs_sv", 32'(sv[0]), 32'b0011);
    chk("xs_en", 32'(se[0]), 0);
    chk("xs_sc0", sc[0], 4);
    chk("xs_sc1", sc[1], 9);
    ext_stall = 1'b0;
    cyc();
    idle(6);

    // asynchronous reset with a full pipe
    put(5'd16, 1, 0, 5'd0, 0, 5'd0, 0);
    put(5'd17, 1, 0, 5'd0, 0, 5'd0, 0);
    put(5'd18, 1, 0, 5'd0, 0, 5'd0, 0);
    put(5'd19, 1, 0, 5'd0, 0, 5'd0, 0);
    if_valid = 1'b0;
    chk("full_sv", 32'(sv[0]), 32'b1111);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sv", 32'(sv[0]), 0);
    chk("arst_rdy", 32'(rdy[0]), 1);
    chk("arst_sc", sc[1], 0);
    chk("arst_fc", fc[0], 0);
    cyc(2);
    rst_n = 1'b1;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
